// File: rtl/ll_req_queue.sv
// Request buffer between the ROM DMA and the linked-list engine: a DEPTH-entry FIFO
// that issues one request at a time and waits for its completion pulse (or a timeout).

package ll_req_pkg;
  localparam int unsigned HEADPTR_ADDR_WIDTH = 4;
  localparam int unsigned NODENUM_WIDTH      = 8;
  localparam int unsigned DATA_WIDTH         = 16;

  typedef enum logic [1:0] {
    MainOpRead, MainOpInsert, MainOpDelete, MainOpUpdate
  } t_mainop_types;

  typedef enum logic [1:0] {
    SpecHead, SpecTail, SpecPos, SpecValue
  } t_specifier_types;

  typedef struct packed {
    t_mainop_types                 main_op;
    t_specifier_types              spec;
    logic [HEADPTR_ADDR_WIDTH-1:0] ll_num_in;
    logic [NODENUM_WIDTH-1:0]      pos;
    logic [DATA_WIDTH-1:0]         data;
  } t_req_entry;
endpackage

module ll_req_queue
  import ll_req_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_req_vld,
  input  t_mainop_types                 in_req_main_op,
  input  t_specifier_types              in_req_spec,
  input  logic [HEADPTR_ADDR_WIDTH-1:0] in_req_ll_num_in,
  input  logic [NODENUM_WIDTH-1:0]      in_req_pos,
  input  logic [DATA_WIDTH-1:0]         in_req_data,
  output logic                          in_ready,
  output logic                          req_vld,
  output t_mainop_types                 req_main_op,
  output t_specifier_types              req_spec,
  output logic [HEADPTR_ADDR_WIDTH-1:0] req_ll_num_in,
  output logic [NODENUM_WIDTH-1:0]      req_pos,
  output logic [DATA_WIDTH-1:0]         req_data,
  input  logic                          intf_ready,
  input  logic                          resp_gen_cmpltd,
  output logic [$clog2(DEPTH):0]        occupancy,
  output logic                          drained,
  output logic                          overflow_err,
  output logic                          spurious_rsp_err,
  output logic                          timeout_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StWaitRsp} state_e;

  state_e          state_q;
  t_req_entry      mem_q [DEPTH];
  t_req_entry      in_entry;
  t_req_entry      head;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0] occ_q;
  logic [TmoW-1:0] tmo_cnt_q;
  logic            push, pop;

  assign in_entry = '{main_op:   in_req_main_op,
                      spec:      in_req_spec,
                      ll_num_in: in_req_ll_num_in,
                      pos:       in_req_pos,
                      data:      in_req_data};

  // Purely registered: a pop in the same cycle does not free a slot for a push.
  assign in_ready = (occ_q != OccW'(DEPTH));
  assign req_vld  = (state_q == StIdle) && (occ_q != '0);
  assign push     = in_req_vld && in_ready;
  assign pop      = req_vld && intf_ready;

  assign head          = mem_q[rd_ptr_q];
  assign req_main_op   = head.main_op;
  assign req_spec      = head.spec;
  assign req_ll_num_in = head.ll_num_in;
  assign req_pos       = head.pos;
  assign req_data      = head.data;

  assign occupancy = occ_q;
  assign drained   = (occ_q == '0) && (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      occ_q            <= '0;
      tmo_cnt_q        <= '0;
      overflow_err     <= 1'b0;
      spurious_rsp_err <= 1'b0;
      timeout_err      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_entry;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);

      case ({push, pop})
        2'b10:   occ_q <= occ_q + OccW'(1);
        2'b01:   occ_q <= occ_q - OccW'(1);
        default: ;
      endcase

      if (in_req_vld && !in_ready) overflow_err <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (pop) begin
            tmo_cnt_q <= '0;
            state_q   <= StWaitRsp;
          end
          if (resp_gen_cmpltd) spurious_rsp_err <= 1'b1;
        end
        StWaitRsp: begin
          // A response arriving on the last allowed cycle still counts as on time.
          if (resp_gen_cmpltd) begin
            state_q <= StIdle;
          end else if (tmo_cnt_q == TmoMax) begin
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ll_req_queue.sv
// Self-checking bench for ll_req_queue: table-driven fill vectors plus scripted
// sequences; issued requests are checked against a scoreboard of accepted pushes.

module tb_ll_req_queue;
  import ll_req_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 8;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          in_req_vld;
  t_mainop_types                 in_req_main_op;
  t_specifier_types              in_req_spec;
  logic [HEADPTR_ADDR_WIDTH-1:0] in_req_ll_num_in;
  logic [NODENUM_WIDTH-1:0]      in_req_pos;
  logic [DATA_WIDTH-1:0]         in_req_data;
  logic                          in_ready;
  logic                          req_vld;
  t_mainop_types                 req_main_op;
  t_specifier_types              req_spec;
  logic [HEADPTR_ADDR_WIDTH-1:0] req_ll_num_in;
  logic [NODENUM_WIDTH-1:0]      req_pos;
  logic [DATA_WIDTH-1:0]         req_data;
  logic                          intf_ready;
  logic                          resp_gen_cmpltd;
  logic [$clog2(DEPTH):0]        occupancy;
  logic                          drained;
  logic                          overflow_err;
  logic                          spurious_rsp_err;
  logic                          timeout_err;

  ll_req_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_req_vld       (in_req_vld),
    .in_req_main_op   (in_req_main_op),
    .in_req_spec      (in_req_spec),
    .in_req_ll_num_in (in_req_ll_num_in),
    .in_req_pos       (in_req_pos),
    .in_req_data      (in_req_data),
    .in_ready         (in_ready),
    .req_vld          (req_vld),
    .req_main_op      (req_main_op),
    .req_spec         (req_spec),
    .req_ll_num_in    (req_ll_num_in),
    .req_pos          (req_pos),
    .req_data         (req_data),
    .intf_ready       (intf_ready),
    .resp_gen_cmpltd  (resp_gen_cmpltd),
    .occupancy        (occupancy),
    .drained          (drained),
    .overflow_err     (overflow_err),
    .spurious_rsp_err (spurious_rsp_err),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_pops = 0;
  t_req_entry sb[$];

  typedef struct {
    logic             vld;
    t_mainop_types    op;
    t_specifier_types spec;
    logic [3:0]       ll;
    logic [7:0]       pos;
    logic [15:0]      data;
    logic             exp_in_ready;
    int               exp_occ;
    logic             exp_req_vld;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: at the falling edge any handshake is compared with the scoreboard head,
  // then advance to 1 time unit past the next rising edge.
  task automatic cycle();
    t_req_entry exp, act;
    @(negedge clk);
    if (!reset && req_vld && intf_ready) begin
      n_pops++;
      checks++;
      act = '{main_op: req_main_op, spec: req_spec, ll_num_in: req_ll_num_in,
              pos: req_pos, data: req_data};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got 0x%0h expected no issue", act);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL issue_fields: got 0x%0h expected 0x%0h", act, exp);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input t_mainop_types op, input t_specifier_types spec,
                      input logic [3:0] ll, input logic [7:0] pos, input logic [15:0] data,
                      input bit accept);
    in_req_vld       = 1'b1;
    in_req_main_op   = op;
    in_req_spec      = spec;
    in_req_ll_num_in = ll;
    in_req_pos       = pos;
    in_req_data      = data;
    if (accept) sb.push_back('{main_op: op, spec: spec, ll_num_in: ll, pos: pos, data: data});
    cycle();
    in_req_vld = 1'b0;
  endtask

  // Accept the head request (bounded wait), then respond after lat cycles.
  task automatic issue_rsp(input int lat);
    int p0 = n_pops;
    intf_ready = 1'b1;
    for (int i = 0; i < 20 && n_pops == p0; i++) cycle();
    chk("issue_seen", 32'(n_pops != p0), 32'd1);
    intf_ready = 1'b0;
    repeat (lat) cycle();
    resp_gen_cmpltd = 1'b1;
    cycle();
    resp_gen_cmpltd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{1'b1, MainOpInsert, SpecHead,  4'h1, 8'h10, 16'h1111, 1'b1, 0, 1'b0};
    vecs[1] = '{1'b1, MainOpDelete, SpecTail,  4'h2, 8'h20, 16'h2222, 1'b1, 1, 1'b1};
    vecs[2] = '{1'b1, MainOpUpdate, SpecPos,   4'h3, 8'h30, 16'h3333, 1'b1, 2, 1'b1};
    vecs[3] = '{1'b1, MainOpRead,   SpecValue, 4'h4, 8'h40, 16'h4444, 1'b1, 3, 1'b1};
    vecs[4] = '{1'b1, MainOpInsert, SpecPos,   4'h5, 8'h50, 16'h5555, 1'b0, 4, 1'b1};
    vecs[5] = '{1'b0, MainOpRead,   SpecHead,  4'h0, 8'h00, 16'h0000, 1'b0, 4, 1'b1};

    reset = 1'b1; in_req_vld = 1'b0; intf_ready = 1'b0; resp_gen_cmpltd = 1'b0;
    in_req_main_op = MainOpRead; in_req_spec = SpecHead;
    in_req_ll_num_in = '0; in_req_pos = '0; in_req_data = '0;
    cycle(); cycle();
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_req_vld", 32'(req_vld), 32'd0);
    chk("rst_drained", 32'(drained), 32'd1);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_errs", {29'd0, overflow_err, spurious_rsp_err, timeout_err}, 32'd0);
    chk("rst_fields", {8'(req_pos), req_data}, 32'd0);

    // Single request: visible one cycle after the push
    intf_ready = 1'b1;
    push(MainOpInsert, SpecPos, 4'h7, 8'd3, 16'h00A5, 1'b1);
    chk("single_req_vld", 32'(req_vld), 32'd1);
    chk("single_occ", 32'(occupancy), 32'd1);
    cycle();
    chk("single_wait_vld", 32'(req_vld), 32'd0);
    chk("single_wait_drained", 32'(drained), 32'd0);
    repeat (4) cycle();
    resp_gen_cmpltd = 1'b1;
    cycle();
    resp_gen_cmpltd = 1'b0;
    chk("single_drained", 32'(drained), 32'd1);
    chk("single_no_spur", 32'(spurious_rsp_err), 32'd0);

    // Fill to full with the engine stalled; 5th push overflows
    intf_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fill%0d_occ", i), 32'(occupancy), 32'(vecs[i].exp_occ));
      chk($sformatf("fill%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
      chk($sformatf("fill%0d_req_vld", i), 32'(req_vld), 32'(vecs[i].exp_req_vld));
      if (vecs[i].vld) begin
        push(vecs[i].op, vecs[i].spec, vecs[i].ll, vecs[i].pos, vecs[i].data,
             vecs[i].exp_in_ready);
      end else begin
        cycle();
      end
    end
    chk("fill_overflow", 32'(overflow_err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      issue_rsp(2);
      // Reissue is possible in the cycle right after the response pulse
      chk($sformatf("b2b%0d_req_vld", i), 32'(req_vld), 32'(i < 3));
    end
    chk("fill_drained", 32'(drained), 32'd1);
    chk("fill_sb_empty", 32'(sb.size()), 32'd0);

    // Simultaneous push and pop at occupancy 2, wrapping the pointers
    push(MainOpUpdate, SpecHead, 4'h8, 8'h80, 16'h8000, 1'b1);
    push(MainOpUpdate, SpecTail, 4'h9, 8'h81, 16'h8001, 1'b1);
    for (int i = 0; i < 10; i++) begin
      intf_ready = 1'b1;
      push(t_mainop_types'(i % 4), t_specifier_types'((i + 1) % 4), 4'(i), 8'(i * 7),
           16'(16'hC000 + i), 1'b1);
      intf_ready = 1'b0;
      chk($sformatf("simul%0d_occ", i), 32'(occupancy), 32'd2);
      resp_gen_cmpltd = 1'b1;
      cycle();
      resp_gen_cmpltd = 1'b0;
      chk($sformatf("simul%0d_req_vld", i), 32'(req_vld), 32'd1);
    end
    issue_rsp(1);
    issue_rsp(0);
    chk("simul_drained", 32'(drained), 32'd1);
    chk("simul_sb_empty", 32'(sb.size()), 32'd0);

    // Timeout: 8 cycles in WAIT_RSP, then the next entry is offered
    push(MainOpDelete, SpecValue, 4'hA, 8'hA0, 16'hAAAA, 1'b1);
    push(MainOpInsert, SpecValue, 4'hB, 8'hB0, 16'hBBBB, 1'b1);
    intf_ready = 1'b1;
    cycle();
    intf_ready = 1'b0;
    repeat (7) cycle();
    chk("tmo_not_yet", 32'(timeout_err), 32'd0);
    chk("tmo_wait_vld", 32'(req_vld), 32'd0);
    cycle();
    chk("tmo_err", 32'(timeout_err), 32'd1);
    chk("tmo_next_vld", 32'(req_vld), 32'd1);
    chk("tmo_occ", 32'(occupancy), 32'd1);
    issue_rsp(1);
    chk("tmo_drained", 32'(drained), 32'd1);

    // Spurious response while idle and empty
    chk("spur_clear", 32'(spurious_rsp_err), 32'd0);
    resp_gen_cmpltd = 1'b1;
    cycle();
    resp_gen_cmpltd = 1'b0;
    chk("spur_err", 32'(spurious_rsp_err), 32'd1);
    chk("spur_drained", 32'(drained), 32'd1);
    chk("spur_occ", 32'(occupancy), 32'd0);

    // Reset while waiting with 3 entries queued
    for (int i = 0; i < 4; i++) push(MainOpRead, SpecPos, 4'(i), 8'(i), 16'(16'hD0 + i), 1'b1);
    intf_ready = 1'b1;
    cycle();
    intf_ready = 1'b0;
    chk("rstmid_pre_occ", 32'(occupancy), 32'd3);
    chk("rstmid_pre_vld", 32'(req_vld), 32'd0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    sb.delete();
    chk("rstmid_occ", 32'(occupancy), 32'd0);
    chk("rstmid_req_vld", 32'(req_vld), 32'd0);
    chk("rstmid_drained", 32'(drained), 32'd1);
    chk("rstmid_errs", {29'd0, overflow_err, spurious_rsp_err, timeout_err}, 32'd0);
    chk("rstmid_data", 32'(req_data), 32'd0);
    resp_gen_cmpltd = 1'b1;
    cycle();
    resp_gen_cmpltd = 1'b0;
    chk("rstmid_spur", 32'(spurious_rsp_err), 32'd1);
    chk("rstmid_still_drained", 32'(drained), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
